aes_ctr_stream: RTL and testbench

CTR-mode streaming front/back end for the hardened AES-128 encryptor (`aes_top`). It accepts 128-bit data blocks on a valid/ready stream and drives the encryptor one counter block at a time. It XORs the returned keystream with the data and emits the result on a valid/ready output stream. It consumes the encryptor's `done` and `fault_flag` to retry faulted blocks, and raises a sticky alarm on persistent fault or timeout.

---
 rtl/aes_pkg.sv | 16 +
 rtl/ctr_inc.sv | 14 +
 rtl/aes_ctr_stream.sv | 159 +++++++++++++++
 tb/tb_aes_ctr_stream.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared state encoding and block width for the AES CTR stream front end

package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READY  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_OUTPUT = 3'd4,
        S_ALARM  = 3'd5
    } state_e;

endpackage

// File: rtl/ctr_inc.sv
// rtl/ctr_inc.sv - increment of the low counter bits with wrap indication

module ctr_inc #(
    parameter int CTR_W = 32
) (
    input  logic [CTR_W-1:0] ctr_i,
    output logic [CTR_W-1:0] ctr_o,
    output logic             wrap_o
);

    assign ctr_o  = ctr_i + CTR_W'(1);
    assign wrap_o = &ctr_i;

endmodule

// File: rtl/aes_ctr_stream.sv
// rtl/aes_ctr_stream.sv - CTR-mode stream wrapper driving the AES-128 encryptor one block at a time

module aes_ctr_stream
    import aes_pkg::*;
#(
    parameter int CTR_W     = 32,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load,
    input  logic [AES_BLK_W-1:0] cfg_key,
    input  logic [AES_BLK_W-1:0] cfg_iv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 aes_start,
    output logic [AES_BLK_W-1:0] aes_key,
    output logic [AES_BLK_W-1:0] aes_block,
    input  logic                 aes_busy,
    input  logic                 aes_done,
    input  logic [AES_BLK_W-1:0] aes_ct,
    input  logic                 aes_fault,
    output logic                 alarm,
    output logic                 ctr_wrapped,
    output logic [CNT_W-1:0]     blk_count
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e               state_q, state_d;
    logic [AES_BLK_W-1:0] key_q, key_d;
    logic [AES_BLK_W-1:0] ctr_q, ctr_d;
    logic [AES_BLK_W-1:0] data_q, data_d;
    logic [AES_BLK_W-1:0] out_data_q, out_data_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 wrapped_q, wrapped_d;
    logic [CNT_W-1:0]     blk_q, blk_d;

    logic [CTR_W-1:0]     ctr_lo_inc;
    logic                 ctr_lo_wrap;

    ctr_inc #(.CTR_W(CTR_W)) u_ctr_inc (
        .ctr_i  (ctr_q[CTR_W-1:0]),
        .ctr_o  (ctr_lo_inc),
        .wrap_o (ctr_lo_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            ctr_q      <= '0;
            data_q     <= '0;
            out_data_q <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            wrapped_q  <= 1'b0;
            blk_q      <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            ctr_q      <= ctr_d;
            data_q     <= data_d;
            out_data_q <= out_data_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            wrapped_q  <= wrapped_d;
            blk_q      <= blk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        ctr_d      = ctr_q;
        data_d     = data_q;
        out_data_d = out_data_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        wrapped_d  = wrapped_q;
        blk_d      = blk_q;
        in_ready   = 1'b0;
        aes_start  = 1'b0;

        case (state_q)
            S_IDLE, S_READY: begin
                if (cfg_load) begin
                    key_d     = cfg_key;
                    ctr_d     = cfg_iv;
                    blk_d     = '0;
                    wrapped_d = 1'b0;
                    state_d   = S_READY;
                end else if (state_q == S_READY) begin
                    in_ready = ~wrapped_q;
                    if (in_valid && !wrapped_q) begin
                        data_d  = in_data;
                        retry_d = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!aes_busy) begin
                    aes_start = 1'b1;
                    timer_d   = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (aes_done) begin
                    if (!aes_fault) begin
                        out_data_d            = data_q ^ aes_ct;
                        ctr_d[CTR_W-1:0]      = ctr_lo_inc;
                        wrapped_d             = wrapped_q | ctr_lo_wrap;
                        blk_d                 = blk_q + CNT_W'(1);
                        state_d               = S_OUTPUT;
                    end else if (retry_q == RW'(MAX_RETRY)) begin
                        state_d = S_ALARM;
                    end else begin
                        // Re-encrypt the same counter; the faulted keystream is discarded.
                        retry_d = retry_q + RW'(1);
                        state_d = S_ISSUE;
                    end
                end else if (timer_q == TW'(TIMEOUT)) begin
                    state_d = S_ALARM;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    state_d = S_READY;
                end
            end
            S_ALARM: begin
                state_d = S_ALARM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_valid   = (state_q == S_OUTPUT);
    assign alarm       = (state_q == S_ALARM);
    assign out_data    = out_data_q;
    assign aes_key     = key_q;
    assign aes_block   = ctr_q;
    assign ctr_wrapped = wrapped_q;
    assign blk_count   = blk_q;

endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb/tb_aes_ctr_stream.sv - scoreboard bench with encryptor model and CTR reference model

module tb_aes_ctr_stream;

    localparam int TIMEOUT   = 255;
    localparam int MAX_RETRY = 2;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] KS1 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] KS2 = 128'h362b7c3c6773516318a077d7fc5073ae;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_load = 1'b0;
    logic [127:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         aes_start;
    logic [127:0] aes_key;
    logic [127:0] aes_block;
    logic         aes_busy;
    logic         aes_done = 1'b0;
    logic [127:0] aes_ct = '0;
    logic         aes_fault = 1'b0;
    logic         alarm;
    logic         ctr_wrapped;
    logic [15:0]  blk_count;

    aes_ctr_stream #(.CTR_W(32), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .aes_start(aes_start), .aes_key(aes_key), .aes_block(aes_block),
        .aes_busy(aes_busy), .aes_done(aes_done), .aes_ct(aes_ct), .aes_fault(aes_fault),
        .alarm(alarm), .ctr_wrapped(ctr_wrapped), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Stand-in encryptor: two SP800-38A keystream blocks, synthetic keystream elsewhere.
    function automatic logic [127:0] ks(input logic [127:0] k, input logic [127:0] b);
        if (k == K1 && b == IV1) return KS1;
        if (k == K1 && b == IV2) return KS2;
        return (k ^ {b[63:0], b[127:64]}) + {b[31:0], b[127:32]} + 128'h9e3779b97f4a7c15;
    endfunction

    // Encryptor model state
    logic         force_busy = 1'b0;
    logic         model_busy = 1'b0;
    bit           hang = 1'b0;
    bit           kill = 1'b0;
    int           lat_fix = 0;
    bit           pend = 1'b0;
    int           cnt = 0;
    bit           cur_fault = 1'b0;
    logic [127:0] cur_blk, cur_key;
    int           starts = 0;
    int           start_cyc = 0;
    logic [127:0] start_blocks[$];
    bit           fault_plan[$];

    assign aes_busy = force_busy | model_busy;

    always begin
        bit st;
        @(negedge clk);
        #2;
        st = aes_start;
        aes_done  = 1'b0;
        aes_fault = 1'b0;
        if (kill) begin
            pend       = 1'b0;
            model_busy = 1'b0;
            st         = 1'b0;
        end
        if (pend) begin
            model_busy = 1'b1;
            if (cnt <= 1) begin
                if (!hang) begin
                    aes_done  = 1'b1;
                    aes_fault = cur_fault;
                    aes_ct    = cur_fault ? ~ks(cur_key, cur_blk) : ks(cur_key, cur_blk);
                end
                pend       = 1'b0;
                model_busy = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (st) begin
            pend      = 1'b1;
            cnt       = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 8));
            cur_fault = (fault_plan.size() > 0) ? fault_plan.pop_front() : 1'b0;
            cur_blk   = aes_block;
            cur_key   = aes_key;
            starts++;
            start_cyc = cyc;
            start_blocks.push_back(aes_block);
        end
    end

    // Output handshake control
    bit   rand_rdy = 1'b0;
    logic ready_man = 1'b1;
    logic rr = 1'b1;
    assign out_ready = rand_rdy ? rr : ready_man;
    always begin
        @(negedge clk);
        rr = 1'($urandom_range(0, 1));
    end

    // Reference model: counter block and block count follow the CTR rules directly.
    logic [127:0] m_key = '0, m_ctr = '0;
    logic [15:0]  m_cnt = '0;
    bit           m_wrapped = 1'b0;
    logic [127:0] exp_q[$];
    logic [15:0]  exp_cnt_q[$];
    logic [127:0] last_out = '0;

    // Monitor
    bit           stall_pending = 1'b0;
    logic [127:0] stall_data;
    always begin
        logic [127:0] e;
        logic [15:0]  ec;
        @(negedge clk);
        #3;
        if (out_valid) begin
            if (stall_pending) chk("out_stable", out_data, stall_data);
            if (out_ready) begin
                stall_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cnt_q.pop_front();
                    chk("out_data", out_data, e);
                    chk("blk_count", {112'd0, blk_count}, {112'd0, ec});
                end
                last_out = out_data;
            end else begin
                stall_pending = 1'b1;
                stall_data    = out_data;
            end
        end else begin
            stall_pending = 1'b0;
        end
    end

    task automatic cfg(input logic [127:0] k, input logic [127:0] iv, input bit upd, input bit chk_rdy);
        cfg_load = 1'b1;
        cfg_key  = k;
        cfg_iv   = iv;
        #1;
        if (chk_rdy) chk("in_ready_during_cfg", {127'd0, in_ready}, 128'd0);
        @(negedge clk);
        cfg_load = 1'b0;
        if (upd) begin
            m_key     = k;
            m_ctr     = iv;
            m_cnt     = '0;
            m_wrapped = 1'b0;
        end
    endtask

    task automatic send(input logic [127:0] d, input bit push);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("send_accept");
        else if (push) begin
            exp_q.push_back(d ^ ks(m_key, m_ctr));
            m_cnt = m_cnt + 16'd1;
            exp_cnt_q.push_back(m_cnt);
            if (m_ctr[31:0] == 32'hffffffff) m_wrapped = 1'b1;
            m_ctr = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #4;
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain");
        @(negedge clk);
    endtask

    task automatic wait_alarm(output int at);
        at = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (alarm) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now("wait_alarm");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        kill  = 1'b1;
        fault_plan.delete();
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_cnt_q.delete();
        kill = 1'b0;
        #1;
        chk("rst_flags", {123'd0, in_ready, out_valid, aes_start, alarm, ctr_wrapped}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_aes_key", aes_key, 128'd0);
        chk("rst_aes_block", aes_block, 128'd0);
        chk("rst_blk_count", {112'd0, blk_count}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r, up;
        int s0, n0, at;
        @(negedge clk);
        do_reset();

        // Vector 1, with a reload from READY first
        cfg(128'h1, 128'h2, 1'b1, 1'b0);
        cfg(K1, IV1, 1'b1, 1'b1);
        #1;
        chk("cfg_key_loaded", aes_key, K1);
        chk("cfg_iv_loaded", aes_block, IV1);
        @(negedge clk);
        send(128'h6bc1bee22e409f96e93d7e117393172a, 1'b1);
        drain();
        chk("v1_literal", last_out, 128'h874d6191b620e3261bef6864990db6ce);
        chk("v1_next_ctr", aes_block, IV2);

        // Vector 2 with stalled downstream
        ready_man = 1'b0;
        send(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1);
        at = 0;
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        #1;
        if (!out_valid) fail_now("v2_out_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
        end
        ready_man = 1'b1;
        drain();
        chk("v2_literal", last_out, 128'h9806f66b7970fdff8617187bb9fffdff);

        // Random traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        drain();
        rand_rdy = 1'b0;

        // One fault then clean retry
        s0 = starts;
        fault_plan.push_back(1'b1);
        fault_plan.push_back(1'b0);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        drain();
        n0 = start_blocks.size();
        chk("retry_starts", 128'(starts - s0), 128'd2);
        chk("retry_same_block", start_blocks[n0-1], start_blocks[n0-2]);
        chk("retry_no_alarm", {127'd0, alarm}, 128'd0);

        // Retry exhaustion
        s0 = starts;
        for (int i = 0; i <= MAX_RETRY; i++) fault_plan.push_back(1'b1);
        r = aes_key;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_alarm(at);
        chk("exhaust_starts", 128'(starts - s0), 128'(MAX_RETRY + 1));
        cfg(~r, 128'h5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("alarm_sticky", {126'd0, alarm, in_ready}, 128'd2);
        end
        chk("alarm_ignores_cfg", aes_key, r);
        do_reset();

        // Timeout: encryptor never answers
        cfg(K1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        hang = 1'b1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_alarm(at);
        chk("timeout_not_early", 128'(at - start_cyc >= TIMEOUT), 128'd1);
        chk("timeout_not_late", 128'(at - start_cyc <= TIMEOUT + 2), 128'd1);
        hang = 1'b0;
        do_reset();

        // Counter wrap
        up = {$urandom, $urandom, $urandom, 32'hffffffff};
        cfg(K1, up, 1'b1, 1'b0);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        drain();
        #1;
        chk("wrap_ctr", aes_block, {up[127:32], 32'h0});
        chk("wrap_flag", {127'd0, ctr_wrapped}, {127'd0, m_wrapped});
        chk("wrap_blocks_in", {127'd0, in_ready}, 128'd0);
        @(negedge clk);
        cfg(K1, IV1, 1'b1, 1'b1);
        #1;
        chk("wrap_cleared", {126'd0, ctr_wrapped, in_ready}, 128'd1);
        @(negedge clk);

        // Reset mid-WAIT
        lat_fix = 30;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (6) @(negedge clk);
        do_reset();
        lat_fix = 0;

        // cfg_load while in ISSUE is ignored
        cfg(K1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        force_busy = 1'b1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        @(negedge clk);
        cfg(~m_key, ~m_ctr, 1'b0, 1'b0);
        #1;
        chk("issue_cfg_key", aes_key, m_key);
        chk("issue_cfg_ctr", aes_block, m_ctr - 128'd1);
        @(negedge clk);
        force_busy = 1'b0;
        drain();
        chk("issue_blk_count", {112'd0, blk_count}, 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
